// File: rtl/osd_perm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osd_perm_pkg
// Purpose  : Shared types and constants for the OSD inverse-permutation
//            stream block: state encoding, counter width helper and the
//            reset value of inverse slots.
// Revision : 1.0 - initial release
// ============================================================================
package osd_perm_pkg;

  // Load the permutation, then drain its inverse; the two never overlap.
  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  // Value held by every inverse slot after reset/flush/frame end, and by
  // any slot that no input entry wrote.
  localparam int c_INV_RESET = 0;

  // Counters carry one extra bit so that N = 2**WIDTH cannot wrap early.
  function automatic int cnt_width(input int width);
    return width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perm_seen_tracker.sv
`default_nettype none
// ============================================================================
// Module   : perm_seen_tracker
// Purpose  : Malformed-permutation detector. Keeps an N-bit bitmap of the
//            indices accepted in the current frame and raises a sticky
//            error on an out-of-range index or a repeated index.
// Revision : 1.0 - initial release
// ============================================================================
module perm_seen_tracker
  import osd_perm_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_strobe,
  input  logic [WIDTH-1:0] i_idx,
  output logic             o_err
);

  localparam int            CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_N = CW'(N);

  logic [N-1:0] r_seen;
  logic         r_err;
  logic         w_in_range;
  logic         w_dup;

  assign w_in_range = ({1'b0, i_idx} < c_N);
  assign o_err      = r_err;

  // Look up whether the incoming index was already accepted this frame.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_idx == WIDTH'(i) && r_seen[i]) begin
        w_dup = 1'b1;
      end
    end
  end

  // Bitmap and sticky error; both clear together with the inverse array.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_seen <= '0;
      r_err  <= 1'b0;
    end else if (i_strobe) begin
      if (!w_in_range || w_dup) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (i_idx == WIDTH'(i)) begin
          r_seen[i] <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/perm_inverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : perm_inverse_stream
// Purpose  : Accepts a length-N permutation lambda one entry per cycle and
//            builds inv[lambda[j]] = j, then streams inv[] out and exposes it
//            as a flat bus. Optional malformed-frame detection is compiled in
//            with macro PERM_INVERSE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module perm_inverse_stream
  import osd_perm_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH-1:0]   out_idx,
  output logic               out_last,
  output logic [N*WIDTH-1:0] inv_flat,
  output logic               inv_valid,
  output logic               perm_err
);

  localparam int               CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]    c_LAST    = CW'(N - 1);
  localparam logic [CW-1:0]    c_N       = CW'(N);
  localparam logic [WIDTH-1:0] c_INV_RST = WIDTH'(c_INV_RESET);

  state_t           r_state;
  state_t           w_state_n;
  logic [CW-1:0]    r_j;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_inv [N];
  logic             w_acc;
  logic             w_drain;
  logic             w_last;
  logic             w_frame_end;
  logic             w_in_range;
  logic [WIDTH-1:0] w_out_data;

  assign w_last      = (r_k == c_LAST);
  assign w_frame_end = w_drain && w_last;
  assign w_in_range  = ({1'b0, in_data} < c_N);

  assign out_idx  = r_k[WIDTH-1:0];
  assign out_data = w_out_data;
  assign out_last = (r_state == S_OUT) && w_last;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state, handshakes and state-decoded outputs; flush drops handshakes.
  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    inv_valid = 1'b0;
    w_acc     = 1'b0;
    w_drain   = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        w_acc    = in_valid && !flush;
        if (w_acc && r_j == c_LAST) begin
          w_state_n = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        inv_valid = 1'b1;
        w_drain   = out_ready && !flush;
        if (w_drain && w_last) begin
          w_state_n = S_LOAD;
        end
      end
      default: w_state_n = S_LOAD;
    endcase
    if (flush) begin
      w_state_n = S_LOAD;
    end
  end

  // Input and output beat counters.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_j <= '0;
      r_k <= '0;
    end else begin
      if (w_acc) begin
        r_j <= (r_j == c_LAST) ? '0 : r_j + 1'b1;
      end
      if (w_drain) begin
        r_k <= w_last ? '0 : r_k + 1'b1;
      end
    end
  end

  // Inverse array: scatter j into slot lambda[j]; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || w_frame_end) begin
      for (int i = 0; i < N; i++) begin
        r_inv[i] <= c_INV_RST;
      end
    end else if (w_acc && w_in_range) begin
      for (int i = 0; i < N; i++) begin
        if (in_data == WIDTH'(i)) begin
          r_inv[i] <= r_j[WIDTH-1:0];
        end
      end
    end
  end

  // Select inv[k] for the output stream.
  always_comb begin
    w_out_data = c_INV_RST;
    for (int i = 0; i < N; i++) begin
      if (r_k == CW'(i)) begin
        w_out_data = r_inv[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign inv_flat[g*WIDTH +: WIDTH] = r_inv[g];
  end

`ifdef PERM_INVERSE_CHECK_EN
  logic w_err;

  perm_seen_tracker #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_seen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (flush || w_frame_end),
    .i_strobe (w_acc),
    .i_idx    (in_data),
    .o_err    (w_err)
  );

  assign perm_err = w_err;
`else
  assign perm_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_perm_inverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_perm_inverse_stream
// Purpose  : Self-checking bench for perm_inverse_stream (N=8 and N=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_perm_inverse_stream;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, out_last, inv_valid, perm_err;
  logic [W-1:0] out_data, out_idx;
  logic [N*W-1:0] inv_flat;

  // Second instance with N not a power of two.
  logic         s6_in_valid = 1'b0;
  logic [2:0]   s6_in_data = '0;
  logic         s6_out_ready = 1'b1;
  logic         s6_in_ready, s6_out_valid, s6_out_last, s6_inv_valid, s6_perm_err;
  logic [2:0]   s6_out_data, s6_out_idx;
  logic [17:0]  s6_inv_flat;

  int total = 0;
  int bad   = 0;
  int stim [N];
  logic [W-1:0] q [$];
  logic [N*W-1:0] exp_flat;
  logic exp_err;

  always #5 clk = ~clk;

  perm_inverse_stream #(.N(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .inv_flat(inv_flat),
    .inv_valid(inv_valid), .perm_err(perm_err)
  );

  perm_inverse_stream #(.N(6), .WIDTH(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s6_in_valid), .in_ready(s6_in_ready), .in_data(s6_in_data),
    .out_valid(s6_out_valid), .out_ready(s6_out_ready), .out_data(s6_out_data),
    .out_idx(s6_out_idx), .out_last(s6_out_last), .inv_flat(s6_inv_flat),
    .inv_valid(s6_inv_valid), .perm_err(s6_perm_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model the frame in stim[], push the expected stream, drive the inputs.
  task automatic send_frame();
    int e [N];
    logic [N-1:0] seen;
    int n;
    seen = '0;
    exp_err = 1'b0;
    for (int k = 0; k < N; k++) e[k] = 0;
    for (int j = 0; j < N; j++) begin
      if (stim[j] < N) begin
        if (seen[stim[j]]) exp_err = 1'b1;
        seen[stim[j]] = 1'b1;
        e[stim[j]] = j;
      end else begin
        exp_err = 1'b1;
      end
    end
`ifndef PERM_INVERSE_CHECK_EN
    exp_err = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      q.push_back(W'(e[k]));
      exp_flat[k*W +: W] = W'(e[k]);
    end
    for (int j = 0; j < N; j++) begin
      in_valid = 1'b1;
      in_data  = W'(stim[j]);
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("in_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("in_ready_low", in_ready, 0);
    chk("inv_valid", inv_valid, 1);
    chk("inv_flat", inv_flat, exp_flat);
    chk("perm_err", perm_err, exp_err);
  endtask

  // Drain N beats against the scoreboard, optionally stalling.
  task automatic drain(input int stall_beat, input int stall_len, input bit rnd,
                       output int low_cnt);
    int nst, n;
    logic [W-1:0] d, ix, exp;
    logic lst;
    low_cnt = 0;
    for (int b = 0; b < N; b++) begin
      nst = (b == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      if (nst > 0) begin
        out_ready = 1'b0;
        d = out_data; ix = out_idx; lst = out_last;
        repeat (nst) @(negedge clk);
        chk("stall_hold", {out_valid, lst ^ out_last, out_idx, out_data}, {1'b1, 1'b0, ix, d});
      end
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid", out_valid, 1);
      if (!in_ready) low_cnt++;
      if (q.size() > 0) exp = q.pop_front();
      else begin
        chk("sb_empty", 1, 0);
        exp = '0;
      end
      chk("out_data", out_data, exp);
      chk("out_idx", out_idx, b);
      chk("out_last", out_last, (b == N - 1));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("back_to_load", {in_ready, out_valid, inv_valid}, 3'b100);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {in_ready, out_valid, out_last, inv_valid, perm_err, out_data, out_idx},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0});
    chk({tag, "_flat"}, inv_flat, 0);
  endtask

  initial begin
    int low;
    int v6 [6];
    logic [2:0] e6 [6];
    logic [17:0] f6;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame.
    stim = '{3, 0, 7, 1, 6, 2, 5, 4};
    send_frame();
    drain(-1, 0, 1'b0, low);

    // Identity, two frames; in_ready low exactly N cycles between them.
    stim = '{0, 1, 2, 3, 4, 5, 6, 7};
    send_frame();
    drain(-1, 0, 1'b0, low);
    chk("ready_gap", low, N);
    send_frame();
    drain(-1, 0, 1'b0, low);

    // Duplicate index: last write wins, unwritten slot reads 0.
    stim = '{0, 0, 2, 3, 4, 5, 6, 7};
    send_frame();
    chk("dup_inv0", inv_flat[0 +: W], 1);
    chk("dup_inv1", inv_flat[W +: W], 0);
    drain(-1, 0, 1'b0, low);

    // Backpressure: 3-cycle stall on beat 2 plus random stalls.
    stim = '{5, 2, 7, 0, 4, 1, 6, 3};
    send_frame();
    drain(2, 3, 1'b1, low);
    chk("after_dup_err_clear", perm_err, 0);

    // Flush after 4 inputs, flush coincident with an input handshake.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = W'(j + 2);
      @(negedge clk);
    end
    flush = 1'b1;
    in_data = 3'd6;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk_reset_vals("flush_load");
    stim = '{7, 6, 5, 4, 3, 2, 1, 0};
    send_frame();
    drain(-1, 0, 1'b0, low);

    // Flush coincident with an output handshake mid-drain.
    stim = '{1, 2, 3, 4, 5, 6, 7, 0};
    send_frame();
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk_reset_vals("flush_out");
    q.delete();

    // Reset in the middle of S_OUT.
    stim = '{6, 4, 2, 0, 7, 5, 3, 1};
    send_frame();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    stim = '{3, 0, 7, 1, 6, 2, 5, 4};
    send_frame();
    drain(-1, 0, 1'b0, low);

    // N=6: index 6 is out of range and must not be written.
    v6 = '{0, 1, 2, 3, 4, 6};
    for (int k = 0; k < 6; k++) e6[k] = (k < 5) ? 3'(k) : 3'd0;
    for (int k = 0; k < 6; k++) f6[k*3 +: 3] = e6[k];
    for (int j = 0; j < 6; j++) begin
      s6_in_valid = 1'b1;
      s6_in_data  = 3'(v6[j]);
      @(negedge clk);
    end
    s6_in_valid = 1'b0;
    chk("n6_flat", s6_inv_flat, f6);
    chk("n6_inv5", s6_inv_flat[15 +: 3], 0);
`ifdef PERM_INVERSE_CHECK_EN
    chk("n6_err", s6_perm_err, 1);
`else
    chk("n6_err", s6_perm_err, 0);
`endif
    for (int b = 0; b < 6; b++) begin
      chk("n6_beat", {s6_out_valid, s6_inv_valid, s6_out_last, s6_out_idx, s6_out_data},
          {1'b1, 1'b1, (b == 5), 3'(b), e6[b]});
      @(negedge clk);
    end
    chk("n6_reload", {s6_in_ready, s6_out_valid, s6_perm_err}, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/perm_inverse_stream.md
Name: perm_inverse_stream

Overview:
- Sequential, parametrised successor to the combinational inverse-permutation logic in the OSD datapath.
- Accepts a length-N permutation lambda one entry per cycle over a valid/ready stream and builds the inverse in a register array, so that inv[lambda[j]] = j.
- Emits the inverse both as a valid/ready stream and as a flat parallel bus, and can optionally flag malformed permutations.
- Sits between the reliability-sort stage and the codeword de-permutation stage.

Parameters:
- N, 8, permutation length; N >= 2.
- WIDTH, $clog2(N), bits per index; WIDTH >= $clog2(N).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort; discards the current frame.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block accepts an input entry.
- in_data  in  WIDTH  lambda[j], where j is the internal input count.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts an output entry.
- out_data  out  WIDTH  inv[k].
- out_idx  out  WIDTH  k.
- out_last  out  1  asserted with k = N-1.
- inv_flat  out  N*WIDTH  inverse array; inv[i] at [i*WIDTH +: WIDTH].
- inv_valid  out  1  inv_flat holds a complete frame (level, high throughout S_OUT).
- perm_err  out  1  frame was not a valid permutation (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock; synchronous active-low reset.
  - The interface is fixed: one clock `clk`, with synchronous, active-low reset `rst_n`.
- Reset values:
  - State S_LOAD; in counter j = 0; out counter k = 0; all inv[] = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; inv_valid = 0; perm_err = 0; out_data = 0; out_idx = 0.
- S_LOAD:
  - in_ready = 1; out_valid = 0.
  - On in_valid & in_ready: if in_data < N, write inv[in_data] <= j. Out-of-range values are never written.
  - Then j increments.
  - On accepting the entry with j = N-1, go to S_OUT next cycle and set j <= 0.
- S_OUT:
  - in_ready = 0; out_valid = 1; inv_valid = 1.
  - out_data = inv[k]; out_idx = k; out_last = (k == N-1).
  - On out_valid & out_ready, k increments.
  - On the handshake with out_last, go to S_LOAD, set k <= 0, clear all inv[] to 0 and clear perm_err.
- Outputs are registered / array-indexed; no combinational path from in_valid or out_ready to any output except through state.
- Latency:
  - First out_valid is one cycle after the last input handshake.
  - Frame turnaround is at least 2N cycles; load and drain never overlap.
- Backpressure: while out_ready = 0, out_data, out_idx and out_last hold stable.
- Duplicate indices: last write wins. Unwritten inverse slots read 0.
- Flush:
  - Any state returns to S_LOAD with j = k = 0, inv[] = 0, perm_err = 0.
  - Flush has priority over a same-cycle input or output handshake; that handshake is dropped.
- Reset mid-frame behaves identically to flush, and also forces all reset values.
- Counter arithmetic is WIDTH+1 bits internally so that N = 2^WIDTH does not wrap early.

Optional Feature:
- Macro: PERM_INVERSE_CHECK_EN.
- Defined:
  - An N-bit seen bitmap is set at inv index in_data on each accepted entry.
  - perm_err is set (sticky for the frame) if in_data >= N or the seen bit is already set.
  - perm_err is valid from the first S_OUT cycle; the output stream still drains normally.
  - The bitmap clears with inv[].
- Undefined: no bitmap is built; perm_err is tied to 0.

Decomposition:
- Package osd_perm_pkg holds:
  - the state enum {S_LOAD, S_OUT};
  - a localparam function for the counter width;
  - the shared constant for the inv reset value (0).
- One natural sub-module, perm_seen_tracker: holds the bitmap, range compare and duplicate detect, with clear/strobe inputs and an err output. It is instantiated only under PERM_INVERSE_CHECK_EN.

Test Plan:
- N=8, stream [3,0,7,1,6,2,5,4] with out_ready=1 -> output stream [1,3,5,0,7,6,4,2], out_last on the 8th beat, perm_err=0, first out_valid 1 cycle after the 8th input.
- Identity [0..7] sent back-to-back for two frames -> each output [0..7]; in_ready is low for exactly 8 cycles between frames.
- With CHECK_EN, input [0,0,2,3,4,5,6,7] -> perm_err=1; inv[0]=1 and inv[1]=0. Without CHECK_EN -> perm_err=0 with the same data.
- N=6, WIDTH=3, input [0,1,2,3,4,6] -> with CHECK_EN perm_err=1; inv[5]=0, since the out-of-range write is dropped.
- Random out_ready toggling (stall 3 cycles on beat 2) -> out_data/out_idx stable during the stall; no beat lost or duplicated.
- Flush after 4 accepted inputs (also flush coincident with a handshake), then a full frame [7,6,5,4,3,2,1,0] -> output [7,6,5,4,3,2,1,0]. Repeat with rst_n low mid-S_OUT -> all outputs return to reset values the next cycle.
